// File: rtl/controle_registrador.sv
`default_nettype none
// ============================================================================
// Module   : controle_registrador
// Purpose  : Round-robin arbiter/write sequencer for one shared W-bit register.
// Revision : 1.0
// ============================================================================
module controle_registrador #(
    parameter int          W    = 8,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [2:0]   req,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    output logic [2:0]   gnt,
    output logic [2:0]   ack,
    output logic [W-1:0] q,
    output logic [1:0]   owner,
    output logic         busy,
    output logic [7:0]   wr_cnt
);

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] CONCEDE  = 2'd1;
    localparam logic [1:0] CONFIRMA = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   r_ultimo;
    logic [1:0]   w_c0, w_c1;
    logic [1:0]   w_win;
    logic         w_owner_req;
    logic [W-1:0] w_owner_data;

    function automatic logic req_bit(input logic [2:0] r, input logic [1:0] i);
        case (i)
            2'd0:    req_bit = r[0];
            2'd1:    req_bit = r[1];
            2'd2:    req_bit = r[2];
            default: req_bit = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        case (i)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    // Search order starts just after the last served requester.
    always_comb begin
        case (r_ultimo)
            2'd0:    begin w_c0 = 2'd1; w_c1 = 2'd2; end
            2'd1:    begin w_c0 = 2'd2; w_c1 = 2'd0; end
            default: begin w_c0 = 2'd0; w_c1 = 2'd1; end
        endcase
        if (req_bit(req, w_c0))
            w_win = w_c0;
        else if (req_bit(req, w_c1))
            w_win = w_c1;
        else
            w_win = r_ultimo;
    end

    always_comb begin
        w_owner_req = req_bit(req, owner);
        case (owner)
            2'd1:    w_owner_data = d1;
            2'd2:    w_owner_data = d2;
            default: w_owner_data = d0;
        endcase
    end

    assign busy = (r_state != OCIOSO);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= OCIOSO;
            r_ultimo <= 2'd2;
            gnt      <= 3'b000;
            ack      <= 3'b000;
            owner    <= 2'd0;
            q        <= INIT;
            wr_cnt   <= 8'd0;
        end else begin
            case (r_state)
                OCIOSO: begin
                    if (req != 3'b000) begin
                        gnt     <= onehot(w_win);
                        owner   <= w_win;
                        r_state <= CONCEDE;
                    end
                end
                CONCEDE: begin
                    if (w_owner_req) begin
                        q        <= w_owner_data;
                        wr_cnt   <= wr_cnt + 8'd1;
                        ack      <= onehot(owner);
                        r_ultimo <= owner;
                        r_state  <= CONFIRMA;
                    end else begin
                        // Requester withdrew: release without touching q or priority.
                        gnt     <= 3'b000;
                        owner   <= 2'd0;
                        r_state <= OCIOSO;
                    end
                end
                CONFIRMA: begin
                    gnt     <= 3'b000;
                    ack     <= 3'b000;
                    owner   <= 2'd0;
                    r_state <= OCIOSO;
                end
                default: begin
                    gnt     <= 3'b000;
                    ack     <= 3'b000;
                    owner   <= 2'd0;
                    r_state <= OCIOSO;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controle_registrador.sv
`default_nettype none
// Testbench for controle_registrador: table-driven arbitration vectors plus
// write scoreboard and hand-written abort/reset/wrap sequences.
module tb_controle_registrador;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] req = 3'b000;
    logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00;
    logic [2:0] gnt, ack;
    logic [7:0] q, wr_cnt;
    logic [1:0] owner;
    logic       busy;

    logic [2:0] req_b = 3'b000;
    logic [2:0] gnt_b, ack_b;
    logic [7:0] q_b, wr_cnt_b;
    logic [1:0] owner_b;
    logic       busy_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] ack;
        logic [7:0] q;
        logic [7:0] cnt;
    } wr_t;
    wr_t sb[$];
    logic [7:0] exp_cnt = 8'd0;

    typedef struct {
        logic [2:0] r;
        logic [7:0] a, b, c;
        logic [2:0] eg;
        logic [7:0] eq;
    } vec_t;
    vec_t tbl[8];

    controle_registrador #(.W(8), .INIT(8'h00)) dut (
        .clk(clk), .clr(clr), .req(req), .d0(d0), .d1(d1), .d2(d2),
        .gnt(gnt), .ack(ack), .q(q), .owner(owner), .busy(busy), .wr_cnt(wr_cnt)
    );

    controle_registrador #(.W(8), .INIT(8'h5A)) dut_init (
        .clk(clk), .clr(clr), .req(req_b), .d0(d0), .d1(d1), .d2(d2),
        .gnt(gnt_b), .ack(ack_b), .q(q_b), .owner(owner_b), .busy(busy_b), .wr_cnt(wr_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx(input logic [2:0] g);
        case (g)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
    endfunction

    // Scoreboard + invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (clr) begin
            chk("gnt_onehot", {31'd0, $onehot0(gnt)}, 32'd1);
            chk("ack_onehot", {31'd0, $onehot0(ack)}, 32'd1);
            chk("busy_vs_gnt", {31'd0, busy}, {31'd0, (gnt != 3'b000)});
            if (ack != 3'b000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {29'd0, ack}, 32'd0);
                end else begin
                    chk("sb_ack", {29'd0, ack}, {29'd0, sb[0].ack});
                    chk("sb_q", {24'd0, q}, {24'd0, sb[0].q});
                    chk("sb_cnt", {24'd0, wr_cnt}, {24'd0, sb[0].cnt});
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        req = 3'b000;
        #1;
        chk("rst_q", {24'd0, q}, 32'h00);
        chk("rst_gnt", {29'd0, gnt}, 32'd0);
        chk("rst_ack", {29'd0, ack}, 32'd0);
        chk("rst_cnt", {24'd0, wr_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        exp_cnt = 8'd0;
        sb.delete();
    endtask

    task automatic txn(input logic [2:0] r, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [2:0] eg, input logic [7:0] eq);
        req = r; d0 = a; d1 = b; d2 = c;
        @(posedge clk); @(negedge clk);
        chk("gnt_E0", {29'd0, gnt}, {29'd0, eg});
        chk("owner_E0", {30'd0, owner}, {30'd0, idx(eg)});
        exp_cnt = exp_cnt + 8'd1;
        sb.push_back('{ack: eg, q: eq, cnt: exp_cnt});
        @(posedge clk); @(negedge clk);
        req = 3'b000;
        @(posedge clk); @(negedge clk);
        chk("gnt_E2", {29'd0, gnt}, 32'd0);
        chk("busy_E2", {31'd0, busy}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'b001, 8'hA5, 8'h00, 8'h00, 3'b001, 8'hA5};
        tbl[1] = '{3'b010, 8'h00, 8'h3C, 8'h00, 3'b010, 8'h3C};
        tbl[2] = '{3'b100, 8'h00, 8'h00, 8'hC3, 3'b100, 8'hC3};
        tbl[3] = '{3'b110, 8'h01, 8'h02, 8'h03, 3'b010, 8'h02};
        tbl[4] = '{3'b101, 8'h04, 8'h05, 8'h06, 3'b100, 8'h06};
        tbl[5] = '{3'b011, 8'h07, 8'h08, 8'h09, 3'b001, 8'h07};
        tbl[6] = '{3'b111, 8'h0A, 8'h0B, 8'h0C, 3'b010, 8'h0B};
        tbl[7] = '{3'b101, 8'h0D, 8'h0E, 8'h0F, 3'b100, 8'h0F};

        // Second instance idles after reset and must hold its INIT value.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("init_q", {24'd0, q_b}, 32'h5A);
            chk("init_busy", {31'd0, busy_b}, 32'd0);
            chk("init_owner", {30'd0, owner_b}, 32'd0);
        end

        // Arbitration table; priority state carries over between entries.
        do_reset();
        for (int i = 0; i < 8; i++)
            txn(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].eg, tbl[i].eq);
        chk("table_cnt", {24'd0, wr_cnt}, 32'd8);

        // Continuous requests from all three: 0,1,2,0 at 3-cycle spacing.
        do_reset();
        sb.push_back('{ack: 3'b001, q: 8'h11, cnt: 8'd1});
        sb.push_back('{ack: 3'b010, q: 8'h22, cnt: 8'd2});
        sb.push_back('{ack: 3'b100, q: 8'h33, cnt: 8'd3});
        sb.push_back('{ack: 3'b001, q: 8'h11, cnt: 8'd4});
        d0 = 8'h11; d1 = 8'h22; d2 = 8'h33; req = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            chk("rr_ack_timing", {31'd0, (ack != 3'b000)}, {31'd0, (k % 3 == 2)});
        end
        req = 3'b000;
        chk("rr_drained", sb.size(), 32'd0);
        chk("rr_cnt", {24'd0, wr_cnt}, 32'd4);

        // Abort: requester 1 drops during CONCEDE.
        do_reset();
        req = 3'b010; d1 = 8'h77;
        @(posedge clk); @(negedge clk);
        chk("abort_gnt", {29'd0, gnt}, 32'b010);
        req = 3'b000;
        @(posedge clk); @(negedge clk);
        chk("abort_gnt_off", {29'd0, gnt}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_q", {24'd0, q}, 32'h00);
        chk("abort_cnt", {24'd0, wr_cnt}, 32'd0);
        txn(3'b011, 8'h44, 8'h55, 8'h00, 3'b001, 8'h44);

        // Asynchronous reset during CONFIRMA of a requester-2 write.
        do_reset();
        req = 3'b100; d2 = 8'hFF;
        @(posedge clk); @(negedge clk);
        sb.push_back('{ack: 3'b100, q: 8'hFF, cnt: 8'd1});
        @(posedge clk); @(negedge clk);
        #2;
        clr = 1'b0;
        #1;
        chk("arst_q", {24'd0, q}, 32'h00);
        chk("arst_gnt", {29'd0, gnt}, 32'd0);
        chk("arst_ack", {29'd0, ack}, 32'd0);
        chk("arst_cnt", {24'd0, wr_cnt}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        req = 3'b000;
        @(negedge clk);
        clr = 1'b1;
        exp_cnt = 8'd0;
        sb.delete();
        txn(3'b100, 8'h00, 8'h00, 8'h0F, 3'b100, 8'h0F);
        chk("arst_after_cnt", {24'd0, wr_cnt}, 32'd1);

        // Write counter wraps modulo 256.
        do_reset();
        for (int i = 1; i <= 257; i++) begin
            txn(3'b001, i[7:0], 8'h00, 8'h00, 3'b001, i[7:0]);
            if (i == 256) chk("wrap_256", {24'd0, wr_cnt}, 32'd0);
            if (i == 257) chk("wrap_257", {24'd0, wr_cnt}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controle_registrador.md
# controle_registrador

Round-robin arbiter and write sequencer that shares one W-bit storage register (preset/clear register datapath) between three requesters. Each requester raises a request with its data. The controller grants one requester at a time, loads that requester's data into the shared register, and returns a one-cycle acknowledge. It sits between the requesting units and the shared register and is the only writer of that register.

## Interface
- W, 8, width of the shared register and of each data input
- INIT, 8'h00, value loaded into q on reset (W bits)
- clk  input  1  clock, all state changes on rising edge
- clr  input  1  reset, asynchronous, active-low
- req  input  3  request per requester; bit i belongs to requester i
- d0  input  W  data of requester 0
- d1  input  W  data of requester 1
- d2  input  W  data of requester 2
- gnt  output  3  one-hot grant, registered
- ack  output  3  one-hot write acknowledge, one-cycle pulse
- q  output  W  shared register contents
- owner  output  2  index of the granted requester while busy, 0 otherwise
- busy  output  1  high whenever the state is not OCIOSO
- wr_cnt  output  8  count of completed writes, wraps modulo 256

## Operation
- FSM states: OCIOSO, CONCEDE, CONFIRMA.
- Internal register `ultimo` (2 bits) holds the last served requester.
- OCIOSO
  - If no req bit is set, stay in OCIOSO.
  - Otherwise pick winner i: the first set req bit in order (ultimo+1), (ultimo+2), (ultimo+3), all mod 3.
  - Set gnt[i]=1 and owner=i, then go to CONCEDE.
- CONCEDE
  - If req[i] is still high: q <= d_i, wr_cnt <= wr_cnt+1, ack[i] <= 1, ultimo <= i, go to CONFIRMA.
  - If req[i] has dropped (abort): no write, no ack, gnt cleared, ultimo unchanged, go to OCIOSO.
  - Requests from other requesters are ignored in this state.
- CONFIRMA
  - ack[i] is high for exactly this cycle. gnt[i] stays high.
  - Next edge: gnt=0, ack=0, owner=0, go to OCIOSO.
- A requester must drop req after seeing ack. A req still high in the following OCIOSO cycle is treated as a new request, at the lowest priority.
- q changes only on a CONCEDE write or on reset. No other path modifies q.
- At most one bit of gnt and at most one bit of ack is high at any time.
- Reset (clr=0, at any time, mid-transaction included) immediately forces:
  - state = OCIOSO, q = INIT, gnt = 0, ack = 0, owner = 0, busy = 0, wr_cnt = 0
  - ultimo = 2, so requester 0 has first priority after reset
  - any in-flight write is lost.

## Timing
- Edge numbering: req[i] is sampled at edge E0 in OCIOSO.
  - gnt[i] is high from E0 to E2.
  - q holds the new value after E1.
  - ack[i] is high from E1 to E2.
  - Back in OCIOSO after E2.
- Latency from req sampled to q updated: 1 cycle. Latency from req sampled to ack: 1 cycle. One transaction occupies 3 cycles.
- Maximum throughput: one write every 3 cycles with continuous requests.
- Data d_i is sampled only at the CONCEDE edge; it must be stable while gnt[i] is high.
- Round-robin bound: a waiting requester is served within 2 other transactions.
- wr_cnt wraps from 255 to 0 without flag or stall.
- Reset release: the first rising edge with clr=1 evaluates OCIOSO normally, so a req already high at that edge gets gnt from that edge.

## Test plan
- Reset, then req=001 with d0=8'hA5 held until ack → gnt=001 at E0, q=8'hA5 and ack=001 at E1, gnt=000 and busy=0 after E2, wr_cnt=1.
- After reset, req=111 held constantly with d0=8'h11, d1=8'h22, d2=8'h33 → writes in order 0,1,2,0; q takes 8'h11, 8'h22, 8'h33, 8'h11 at 3-cycle spacing; never two gnt bits high.
- Abort: req=010, drop req[1] during CONCEDE → no ack, q stays INIT, wr_cnt=0, back in OCIOSO after one cycle. Next req=011 grants 0, because ultimo is unchanged.
- clr pulsed low during CONFIRMA of a d2=8'hFF write → q=INIT, gnt=000, ack=000, wr_cnt=0 immediately, asynchronous to clk. The next req=100 is served from scratch.
- 256 back-to-back single-requester writes → wr_cnt reads 0 after the 256th ack and 1 after the 257th.
- With INIT=8'h5A, hold req=000 for 10 cycles after reset → q=8'h5A, busy=0, owner=0 throughout.
